dratini0_pov_display_top: RTL and testbench
===========================================

DRATINI0_POV_DISPLAY_TOP -- requirements
Module: dratini0_pov_display_top

Interface
- REQ-001: io_in[0] (clk)  input  1  sole clock; all state on rising edge.
- REQ-002: rst_n  input  1  reset, asynchronous, active-low; dedicated port outside io_in.
- REQ-003: io_in[1] (cs_n)  input  1  SPI chip select, active-low.
- REQ-004: io_in[2] (sck)  input  1  SPI clock, mode 0, asynchronous to clk.
- REQ-005: io_in[3] (mosi)  input  1  SPI data, MSB first.
- REQ-006: io_in[4] (hall_in)  input  1  rotation index sensor.
- REQ-007: io_in[5] (hall_invert)  input  1  1 = hall_in is active-low.
- REQ-008: io_in[7:6] (divisor)  input  2  timebase prescale select.
- REQ-009: io_out[7:0] (leds)  output  8  LED column drive, 1 = lit, registered.
- REQ-010: Gate-level netlist SHALL additionally expose vccd1/vssd1 power pins; RTL SHALL NOT.

Function
- REQ-011: cs_n, sck, mosi and hall_eff = hall_in XOR hall_invert SHALL each pass a 2-flop synchronizer before use.
- REQ-012: SPI: mosi sampled on each synchronized sck rising edge while cs_n low; shift register MSB first.
- REQ-013: cs_n falling edge SHALL clear write pointer (4 bits) and bit count.
- REQ-014: Every 8th bit SHALL write the byte to framebuffer[write_ptr] one cycle later, then write_ptr increments, wrapping 15 -> 0.
- REQ-015: cs_n rising edge with a partial byte SHALL discard it; no write.
- REQ-016: Framebuffer: 16 columns x 8 bits; SPI writes allowed at any time, take effect on next displayed sample.
- REQ-017: Tick enable SHALL pulse once every 1, 4, 16, 64 clk cycles for divisor = 0, 1, 2, 3.
- REQ-018: Index event = rising edge of synchronized hall_eff.
- REQ-019: Period counter (12 bits) SHALL increment per tick, saturating at 4095.
- REQ-020: On index: col_len <= period_count[11:4]; period_count, col_timer, column cleared to 0; active <= (col_len_new != 0).
- REQ-021: While active, col_timer increments per tick; when col_timer+1 = col_len, col_timer <= 0 and column increments.
- REQ-022: Column 15 completing SHALL clear active (blank) until next index.
- REQ-023: Period counter saturating at 4095 SHALL clear active (rotor stopped) until next index.
- REQ-024: leds <= framebuffer[column] when active, else 8'h00; one-cycle registered latency.
- REQ-025: Index and tick in same cycle: index wins; counters restart at 0 (tick not counted).
- REQ-026: SPI write and display read of same column in same cycle: display shows old value that cycle.

Reset
- REQ-027: rst_n low SHALL asynchronously clear framebuffer, leds, write_ptr, shift register, bit count, prescaler, period_count, col_len, col_timer, column, active and all synchronizers.
- REQ-028: Reset mid-transfer or mid-rotation SHALL abort; no write completes; leds 8'h00 until an index with nonzero col_len.

Structure
- REQ-029: Shared package SHALL hold NUM_COLS=16, COL_W=4, PERIOD_W=12, COL_LEN_W=8 and the prescale table.
- REQ-030: One sub-module spi_byte_rx (synchronizers, shift register, byte_valid pulse, cs_start pulse); rest in top.

Verification
- REQ-031: Send 16 bytes 0x01,0x02,...,0x80,0xFF,0x00,... via SPI; divisor=0; hall pulses every 320 clks -> col_len=20, leds step through bytes, 20 clks per column.
- REQ-032: hall_invert=1, hall_in idle high, pulses low every 320 clks -> identical output to REQ-031.
- REQ-033: divisor=2, hall period 5120 clks -> each column held 320 clks.
- REQ-034: Send 12 bits then raise cs_n -> framebuffer unchanged; next transfer writes column 0.
- REQ-035: Stop hall pulses -> leds 8'h00 after column 15 completes, remain 0 beyond 4096 ticks.
- REQ-036: Assert rst_n low mid-rotation -> leds 8'h00 immediately; after release leds stay 0 until two index pulses and a reload.

Source files
------------

// File: rtl/dratini0_pov_display_pkg.sv
// dratini0_pov_display_pkg: shared sizes and timebase prescale table for the POV display
package dratini0_pov_display_pkg;
  localparam int NUM_COLS  = 16;
  localparam int COL_W     = 4;
  localparam int PERIOD_W  = 12;
  localparam int COL_LEN_W = 8;
  // Terminal prescaler count per divisor: tick every 1, 4, 16, 64 clocks
  localparam logic [5:0] PRESCALE_MAX [4] = '{6'd0, 6'd3, 6'd15, 6'd63};
endpackage

// File: rtl/dratini0_pov_display_spi_byte_rx.sv
// dratini0_pov_display_spi_byte_rx: synchronised SPI mode-0 byte receiver, MSB first
module dratini0_pov_display_spi_byte_rx (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cs_n_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       cs_start_o
);
  logic [1:0] cs_q, sck_q, mosi_q;
  logic       cs_prev_q, sck_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q, valid_d, start_q, start_d;
  logic       sample, cs_fall;

  assign sample       = sck_q[1] & ~sck_prev_q & ~cs_q[1];
  assign cs_fall      = ~cs_q[1] & cs_prev_q;
  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign cs_start_o   = start_q;

  // Shift on sck rise while selected; bit count is held at zero while deselected so partial bytes vanish
  always_comb begin
    shift_d = sample ? {shift_q[6:0], mosi_q[1]} : shift_q;
    cnt_d   = (cs_q[1] | cs_fall) ? 3'd0 : sample ? cnt_q + 3'd1 : cnt_q;
    valid_d = sample & (cnt_q == 3'd7);
    start_d = cs_fall;
  end

  // Two-flop synchronisers, edge history and receiver state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cs_q       <= '0;
      sck_q      <= '0;
      mosi_q     <= '0;
      cs_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      cs_q       <= {cs_q[0], cs_n_i};
      sck_q      <= {sck_q[0], sck_i};
      mosi_q     <= {mosi_q[0], mosi_i};
      cs_prev_q  <= cs_q[1];
      sck_prev_q <= sck_q[1];
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
    end
  end
endmodule

// File: rtl/dratini0_pov_display_top.sv
// dratini0_pov_display_top: SPI-loaded 16x8 framebuffer swept onto an LED column per rotation
module dratini0_pov_display_top
  import dratini0_pov_display_pkg::*;
(
  input  logic       rst_n,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic                 clk;
  logic [1:0]           divisor;
  logic [7:0]           rx_byte;
  logic                 byte_valid, cs_start, tick, index;
  logic [2:0]           hall_q;
  logic [7:0]           fb_q [NUM_COLS];
  logic [COL_W-1:0]     wptr_q, wptr_d, column_q, column_d;
  logic [5:0]           presc_q, presc_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [COL_LEN_W-1:0] col_len_q, col_len_d, col_timer_q, col_timer_d;
  logic                 active_q, active_d;
  logic [7:0]           leds_q, leds_d;

  assign clk     = io_in[0];
  assign divisor = io_in[7:6];
  assign io_out  = leds_q;
  assign tick    = presc_q >= PRESCALE_MAX[divisor];
  assign index   = hall_q[1] & ~hall_q[2];

  dratini0_pov_display_spi_byte_rx u_rx (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cs_n_i       (io_in[1]),
    .sck_i        (io_in[2]),
    .mosi_i       (io_in[3]),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .cs_start_o   (cs_start)
  );

  // Write pointer, prescaler and the rotation timing that decides which column is lit
  always_comb begin
    wptr_d      = cs_start ? '0 : byte_valid ? wptr_q + 1'b1 : wptr_q;
    presc_d     = tick ? '0 : presc_q + 6'd1;
    period_d    = period_q;
    col_len_d   = col_len_q;
    col_timer_d = col_timer_q;
    column_d    = column_q;
    active_d    = active_q;
    leds_d      = active_q ? fb_q[column_q] : 8'h00;
    if (index) begin
      col_len_d   = period_q[PERIOD_W-1 -: COL_LEN_W];
      period_d    = '0;
      col_timer_d = '0;
      column_d    = '0;
      active_d    = |period_q[PERIOD_W-1 -: COL_LEN_W];
    end else if (tick) begin
      period_d = (&period_q) ? period_q : period_q + 1'b1;
      if (active_q) begin
        if (col_timer_q + 1'b1 == col_len_q) begin
          col_timer_d = '0;
          column_d    = column_q + 1'b1;
          active_d    = column_q != COL_W'(NUM_COLS - 1);
        end else begin
          col_timer_d = col_timer_q + 1'b1;
        end
      end
      if (&period_q) active_d = 1'b0;
    end
  end

  // Hall synchroniser with edge history, framebuffer writes and display state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_q      <= '0;
      for (int i = 0; i < NUM_COLS; i++) fb_q[i] <= '0;
      wptr_q      <= '0;
      presc_q     <= '0;
      period_q    <= '0;
      col_len_q   <= '0;
      col_timer_q <= '0;
      column_q    <= '0;
      active_q    <= 1'b0;
      leds_q      <= '0;
    end else begin
      hall_q      <= {hall_q[1:0], io_in[4] ^ io_in[5]};
      if (byte_valid) fb_q[wptr_q] <= rx_byte;
      wptr_q      <= wptr_d;
      presc_q     <= presc_d;
      period_q    <= period_d;
      col_len_q   <= col_len_d;
      col_timer_q <= col_timer_d;
      column_q    <= column_d;
      active_q    <= active_d;
      leds_q      <= leds_d;
    end
  end
endmodule

// File: tb/tb_dratini0_pov_display_top.sv
// tb_dratini0_pov_display_top: randomized POV display bench against a framebuffer/rotation model
module tb_dratini0_pov_display_top;
  logic       clk, rst_n, cs_n, sck, mosi, hall_in, hall_inv;
  logic [1:0] divisor;
  logic [7:0] io_in, io_out;
  logic [7:0] fb_m [16];
  logic [7:0] tx_q [$];
  int         checks, errors;

  assign io_in = {divisor, hall_inv, hall_in, mosi, sck, cs_n, clk};

  dratini0_pov_display_top dut (
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic v);
    mosi = v;
    step(3);
    sck = 1'b1;
    step(3);
    sck = 1'b0;
  endtask

  // Sends every byte queued in tx_q plus 'extra' trailing random bits in one transfer
  task automatic spi_send(input int extra);
    int ptr;
    ptr  = 0;
    cs_n = 1'b0;
    step(4);
    foreach (tx_q[i]) begin
      for (int b = 7; b >= 0; b--) spi_bit(tx_q[i][b]);
      fb_m[ptr] = tx_q[i];
      ptr = (ptr + 1) % 16;
    end
    for (int b = 0; b < extra; b++) spi_bit(1'($urandom));
    step(4);
    cs_n = 1'b1;
    step(6);
    tx_q.delete();
  endtask

  // Hall pulses every 'period' clocks; from the second pulse on, each column mid-point and the blank tail are checked
  task automatic run_rot(input string name, input int n, input int period, input int t);
    int len, lt;
    len = (period / t) / 16;
    lt  = len * t;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < period; k++) begin
        @(posedge clk);
        #1;
        if (r > 0) begin
          for (int c = 0; c < 16; c++)
            if (k == 4 + c * lt + lt / 2) begin
              checks++;
              if (io_out !== fb_m[c]) begin
                errors++;
                $display("FAIL %s rot%0d col%0d: leds=%h expected=%h", name, r, c, io_out, fb_m[c]);
              end
            end
          if (k == period - 2) begin
            checks++;
            if (io_out !== 8'h00) begin
              errors++;
              $display("FAIL %s rot%0d blank: leds=%h expected=00", name, r, io_out);
            end
          end
        end
        if (k == 0) hall_in = ~hall_inv;
        if (k == 8) hall_in = hall_inv;
      end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    checks++;
    if (io_out !== 8'h00) begin
      errors++;
      $display("FAIL reset: leds=%h expected=00", io_out);
    end
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_pattern;
    for (int i = 0; i < 8; i++) tx_q.push_back(8'(1 << i));
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h00);
    for (int i = 10; i < 16; i++) tx_q.push_back(8'($urandom));
    spi_send(0);
    divisor = 2'd0;
    run_rot("pattern", 4, 330, 1);
  endtask

  task automatic test_hall_invert;
    hall_inv = 1'b1;
    hall_in  = 1'b1;
    step(20);
    run_rot("invert", 3, 330, 1);
    hall_inv = 1'b0;
    hall_in  = 1'b0;
    step(20);
  endtask

  task automatic test_divisor2;
    divisor = 2'd2;
    run_rot("div2", 3, 5280, 16);
    divisor = 2'd0;
  endtask

  task automatic test_partial;
    tx_q.push_back(fb_m[0]);
    spi_send(4);
    run_rot("partial", 2, 330, 1);
    tx_q.push_back(8'($urandom));
    spi_send(0);
    run_rot("after_partial", 2, 330, 1);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom));
    spi_send(0);
    run_rot("wrap", 3, 330, 1);
  endtask

  task automatic test_stop;
    run_rot("pre_stop", 2, 330, 1);
    for (int k = 1; k <= 5000; k++) begin
      step(1);
      if (k % 500 == 0) begin
        checks++;
        if (io_out !== 8'h00) begin
          errors++;
          $display("FAIL stop t%0d: leds=%h expected=00", k, io_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom_range(1, 255)));
    spi_send(0);
    run_rot("pre_reset", 2, 330, 1);
    hall_in = 1'b1;
    step(8);
    hall_in = 1'b0;
    step(82);
    checks++;
    if (io_out !== fb_m[4]) begin
      errors++;
      $display("FAIL mid_rotation col4: leds=%h expected=%h", io_out, fb_m[4]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: leds=%h expected=00", io_out);
    end
    for (int i = 0; i < 16; i++) fb_m[i] = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(2);
    run_rot("post_reset", 3, 330, 1);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom_range(1, 255)));
    spi_send(0);
    run_rot("reload", 3, 330, 1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    sck      = 1'b0;
    mosi     = 1'b0;
    hall_in  = 1'b0;
    hall_inv = 1'b0;
    divisor  = 2'd0;
    for (int i = 0; i < 16; i++) fb_m[i] = 8'h00;
    test_reset;
    test_pattern;
    test_hall_invert;
    test_divisor2;
    test_partial;
    test_wrap;
    test_stop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
